fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage directly upstream of the single-cycle core. It owns the PC register.
//  It issues req/ack reads to a variable-latency instruction memory and presents one instruction
//  at a time to the core. It applies next-PC decisions (sequential, redirect, halt) at commit.
//  Core sees instr/instr_valid/stall; pc and hlt feed the top-level pc/hlt outputs.
// PARAMETERS
//  ADDR_W      16       PC / imem address width (byte address)
//  DATA_W      16       instruction width
//  RESET_PC    16'h0000 PC loaded on reset (bit 0 forced to 0)
//  TIMEOUT_CYC 255      max cycles req may stay high without ack (FETCH_TIMEOUT_EN only)
// PORTS
//  clk          in  1       single clock; all state updates on rising edge
//  rst          in  1       synchronous, active-high reset
//  imem_req     out 1       read request; held high until imem_ack sampled high
//  imem_addr    out ADDR_W  read address; equals pc while imem_req=1, stable until ack
//  imem_ack     in  1       read done this cycle; imem_rdata valid in the same cycle
//  imem_rdata   in  DATA_W  instruction word
//  instr        out DATA_W  registered instruction presented to core
//  instr_valid  out 1       instr is valid and awaiting commit
//  stall        out 1       = ~instr_valid & ~hlt; core must not update architectural state
//  cpu_ready    in  1       core commits instr this cycle (sampled only when instr_valid=1)
//  redirect     in  1       taken branch/jump at commit
//  redirect_pc  in  ADDR_W  target PC; bit 0 ignored (forced 0)
//  hlt_in       in  1       committed instruction is HLT
//  pc           out ADDR_W  PC of instruction being fetched/held
//  hlt          out 1       sticky halt
//  fetch_err    out 1       sticky fetch timeout (0 when FETCH_TIMEOUT_EN undefined)
// BEHAVIOUR
//  States: FETCH, HOLD, HALT, ERR. Reset -> FETCH, pc=RESET_PC, instr=0, instr_valid=0,
//   hlt=0, fetch_err=0, timeout counter=0. imem_req is 0 in the reset cycle.
//  FETCH: imem_req=1, imem_addr=pc. On edge with imem_ack=1: instr<=imem_rdata,
//   instr_valid<=1, state->HOLD. Ack in the first FETCH cycle is legal (zero-wait).
//   Minimum throughput: 2 cycles/instr (1 FETCH + 1 HOLD).
//  HOLD: imem_req=0; instr stays stable until commit. Commit = edge with cpu_ready=1. Priority:
//   hlt_in -> HALT, hlt<=1, pc unchanged.
//   else redirect -> pc<=redirect_pc&~1, state->FETCH.
//   else pc<=pc+2 (mod 2^ADDR_W; 0xFFFE wraps to 0x0000), state->FETCH.
//   instr_valid<=0 on every commit. With cpu_ready=0, HOLD persists indefinitely.
//  redirect/hlt_in/cpu_ready are ignored outside HOLD.
//  imem_ack is ignored outside FETCH; no spurious capture.
//  HALT: no requests, instr_valid=0, stall=0, hlt=1. Exits only via rst.
//  ERR: imem_req=0, fetch_err=1, hlt=1, instr_valid=0. Exits only via rst.
//  rst at any time, including with a request pending, aborts in that edge. imem_req=0 next cycle.
//   Memory tolerates an abandoned request.
//  imem_addr=pc always. Outputs are glitch-free registered state plus state decode.
// CONFIGURATION
//  FETCH_TIMEOUT_EN defined:
//   - Counter increments each FETCH cycle without ack and clears on ack or on entering FETCH.
//   - When the counter = TIMEOUT_CYC with no ack that cycle -> ERR.
//   - Ack in the same cycle wins over timeout.
//  FETCH_TIMEOUT_EN undefined: no counter logic, ERR unreachable, fetch_err tied 0,
//   FETCH waits forever for ack.
// TESTING
//  1 Reset, 0-wait mem returning 16'hA000+addr, cpu_ready=1 -> pc 0,2,4,...;
//    instr_valid every other cycle; instr=A000,A002,...
//  2 Ack latency 3, cpu_ready low 2 cycles in HOLD -> req held 4 cycles, addr stable,
//    instr stable, stall=1 only in FETCH.
//  3 Commit at pc=0x0010 with redirect=1, redirect_pc=0x0041 -> next imem_addr=0x0040;
//    with hlt_in=1 simultaneously -> HALT, pc stays 0x0010, no further req.
//  4 Preload via redirect to 0xFFFE, commit sequentially -> next fetch at 0x0000.
//  5 rst asserted in 2nd cycle of a pending request, then ack arrives -> ack ignored,
//    pc=RESET_PC, fresh fetch after rst drops.
//  6 FETCH_TIMEOUT_EN, TIMEOUT_CYC=4, never ack -> ERR after 5th FETCH cycle, fetch_err=1, hlt=1,
//    req=0; ack on the 5th cycle instead -> normal HOLD.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, imem req/ack reader, single-instruction hold for the core.
// Optional FETCH_TIMEOUT_EN adds a stuck-request watchdog into ERR.
module fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              stall,
  input  logic              cpu_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              hlt_in,
  output logic [ADDR_W-1:0] pc,
  output logic              hlt,
  output logic              fetch_err
);

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    HALT,
    ERR
  } state_t;

  localparam logic [ADDR_W-1:0] EVEN =
    ~ADDR_W'(1);

  state_t state;
  state_t state_d;
  logic   in_fetch;
  logic   cap;
  logic   commit;
  logic   tmo;

  assign in_fetch = (state == FETCH);
  assign cap      = in_fetch & imem_ack;
  assign commit   = (state == HOLD) & cpu_ready;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  assign tmo = in_fetch & ~imem_ack &
               (cnt == CW'(TIMEOUT_CYC));

  // count unacked fetch cycles; cleared outside FETCH so each fetch starts at 0
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (!in_fetch || imem_ack)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  // sticky error flag raised by the watchdog
  always_ff @(posedge clk) begin
    if (rst)
      fetch_err <= 1'b0;
    else if (tmo)
      fetch_err <= 1'b1;
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^TIMEOUT_CYC;
  assign tmo        = 1'b0;
  assign fetch_err  = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst)
      state <= FETCH;
    else
      state <= state_d;
  end

  // next-state decode
  always_comb begin
    state_d = state;
    unique case (state)
      FETCH: begin
        if (imem_ack)
          state_d = HOLD;
        else if (tmo)
          state_d = ERR;
      end
      HOLD: begin
        if (cpu_ready)
          state_d = hlt_in ? HALT : FETCH;
      end
      default: state_d = state;
    endcase
  end

  // pc, held instruction and halt flag
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC & EVEN;
      instr       <= '0;
      instr_valid <= 1'b0;
      hlt         <= 1'b0;
    end else begin
      if (cap) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
      end
      if (commit) begin
        instr_valid <= 1'b0;
        if (hlt_in)
          hlt <= 1'b1;
        else if (redirect)
          pc <= redirect_pc & EVEN;
        else
          pc <= pc + ADDR_W'(2);
      end
      if (tmo)
        hlt <= 1'b1;
    end
  end

  // reset kills the request in the same cycle
  assign imem_req  = in_fetch & ~rst;
  assign imem_addr = pc;
  assign stall     = ~instr_valid & ~hlt;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit.
// Memory returns A000+addr; expected words queued at ack, checked at commit.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        cpu_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        hlt_in;
  logic [15:0] pc;
  logic        hlt;
  logic        fetch_err;

  int          vecs = 0;
  int          errs = 0;
  int          lat  = 0;
  int          w    = 0;
  logic        auto_mem = 1'b1;
  logic        spur     = 1'b0;
  logic        man_ack  = 1'b0;
  logic [15:0] man_rdata = '0;
  logic [15:0] mpc = '0;
  logic [15:0] q[$];

  fetch_unit #(
    .ADDR_W(16),
    .DATA_W(16),
    .RESET_PC(16'h0000),
    .TIMEOUT_CYC(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .instr(instr),
    .instr_valid(instr_valid),
    .stall(stall),
    .cpu_ready(cpu_ready),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .hlt_in(hlt_in),
    .pc(pc),
    .hlt(hlt),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic mem_step();
    if (!auto_mem) begin
      imem_ack   = man_ack;
      imem_rdata = man_rdata;
      w          = 0;
    end else if (imem_req) begin
      if (w == lat) begin
        imem_ack   = 1'b1;
        imem_rdata = 16'(16'hA000 + imem_addr);
        chk("imem_addr", imem_addr, mpc);
        q.push_back(16'(16'hA000 + mpc));
        w = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 16'($urandom);
        w++;
      end
    end else begin
      imem_ack   = spur;
      imem_rdata = 16'($urandom);
      w          = 0;
    end
  endtask

  task automatic cyc();
    #1 mem_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_req", imem_req, 0);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_instr", instr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_hlt", hlt, 0);
    chk("rst_err", fetch_err, 0);
    chk("rst_stall", stall, 1);
    rst = 1'b0;
    mpc = 16'h0000;
    q.delete();
    #1;
  endtask

  task automatic do_commit(input logic rd,
                           input logic [15:0] tgt,
                           input logic hl,
                           input int k);
    int n;
    logic [15:0] e;
    n = 0;
    while (!instr_valid && n < 400) begin
      chk("req_fetch", imem_req, 1);
      chk("stall_fetch", stall, 1);
      chk("addr_fetch", imem_addr, mpc);
      cyc();
      n++;
    end
    chk("fetch_cycles", n, lat + 1);
    if (!instr_valid) return;
    if (q.size() == 0) begin
      chk("sb_empty", 0, 1);
      e = 16'h0000;
    end else begin
      e = q.pop_front();
    end
    chk("instr", instr, e);
    chk("pc_hold", pc, mpc);
    chk("req_hold", imem_req, 0);
    chk("stall_hold", stall, 0);
    repeat (k) begin
      cyc();
      chk("instr_stable", instr, e);
      chk("valid_stable", instr_valid, 1);
      chk("req_wait", imem_req, 0);
    end
    cpu_ready   = 1'b1;
    redirect    = rd;
    redirect_pc = tgt;
    hlt_in      = hl;
    if (!hl) begin
      if (rd) mpc = tgt & 16'hFFFE;
      else    mpc = 16'(mpc + 16'd2);
    end
    cyc();
    cpu_ready   = 1'b0;
    redirect    = 1'b0;
    hlt_in      = 1'b0;
    redirect_pc = 16'($urandom);
    chk("valid_clr", instr_valid, 0);
  endtask

  initial begin
    rst         = 1'b1;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    cpu_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    hlt_in      = 1'b0;
    @(negedge clk);
    do_reset();

    lat = 0;
    for (int i = 0; i < 6; i++)
      do_commit(0, 16'h0, 0, 0);
    chk("seq_pc", pc, 16'h000C);

    lat  = 3;
    spur = 1'b1;
    do_commit(0, 16'h0, 0, 2);
    do_commit(0, 16'h0, 0, 2);

    lat = 0;
    do_commit(1, 16'h0010, 0, 0);
    do_commit(1, 16'h0041, 0, 0);
    chk("redir_addr", imem_addr, 16'h0040);
    do_commit(1, 16'h0010, 0, 1);
    do_commit(1, 16'h0041, 1, 0);
    for (int i = 0; i < 5; i++) begin
      chk("halt_hlt", hlt, 1);
      chk("halt_pc", pc, 16'h0010);
      chk("halt_req", imem_req, 0);
      chk("halt_valid", instr_valid, 0);
      chk("halt_stall", stall, 0);
      cyc();
    end
    spur = 1'b0;

    do_reset();
    do_commit(1, 16'hFFFE, 0, 0);
    do_commit(0, 16'h0, 0, 0);
    chk("wrap_pc", pc, 16'h0000);
    do_commit(0, 16'h0, 0, 0);

    auto_mem = 1'b0;
    man_ack  = 1'b0;
    cyc();
    chk("pend_req", imem_req, 1);
    rst       = 1'b1;
    man_ack   = 1'b1;
    man_rdata = 16'hBEEF;
    #1;
    chk("rst_cycle_req", imem_req, 0);
    cyc();
    cyc();
    chk("abort_valid", instr_valid, 0);
    chk("abort_instr", instr, 0);
    chk("abort_pc", pc, 16'h0000);
    rst      = 1'b0;
    man_ack  = 1'b0;
    auto_mem = 1'b1;
    mpc      = 16'h0000;
    q.delete();
    #1;
    do_commit(0, 16'h0, 0, 0);

`ifdef FETCH_TIMEOUT_EN
    do_reset();
    lat = 4;
    do_commit(0, 16'h0, 0, 0);
    auto_mem = 1'b0;
    man_ack  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("to_req", imem_req, 1);
      chk("to_err_lo", fetch_err, 0);
      cyc();
    end
    for (int i = 0; i < 3; i++) begin
      chk("to_err", fetch_err, 1);
      chk("to_hlt", hlt, 1);
      chk("to_req_off", imem_req, 0);
      chk("to_valid", instr_valid, 0);
      chk("to_stall", stall, 0);
      cyc();
    end
`else
    do_reset();
    auto_mem = 1'b0;
    man_ack  = 1'b0;
    repeat (300) cyc();
    chk("wait_req", imem_req, 1);
    chk("wait_err", fetch_err, 0);
    chk("wait_hlt", hlt, 0);
    chk("wait_stall", stall, 1);
    chk("wait_pc", pc, 16'h0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
